resamp2x: RTL and testbench

Fractional resampler that converts the ADC-rate I/Q stream into exactly two samples per symbol for the clock-recovery stage directly downstream. A 16-bit phase accumulator, advanced once per input sample, selects output instants. Linear interpolation between adjacent input samples places each output. The block marks every second output as the final sample of the symbol, which drives the recovery stage's `fv`. Software closes the timing loop by writing one-shot phase adjustments derived from the recovery stage's timing error.

---
 rtl/resamp2x_if.sv | 33 +++
 rtl/resamp2x.sv | 137 +++++++++++++
 tb/tb_resamp2x.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/resamp2x_if.sv
// resamp2x_if: sample-stream bundle between the ADC-rate source, the
// resampler and the clock-recovery stage.
//   dix/diy, iv        : signed I/Q input samples and their valid pulse
//   step, recip        : phase increment per input and floor(2^24/step)
//   adj, adjv          : one-shot signed phase adjustment and its strobe
//   slip               : strobe that inverts the half-symbol phase
//   dox/doy, ov, fv    : interpolated samples, output valid, final-sample flag
// The master modport drives the stream into the resampler; the slave modport
// is the resampler's view.
interface resamp2x_if;
  logic signed [7:0]  dix;
  logic signed [7:0]  diy;
  logic               iv;
  logic        [15:0] step;
  logic        [15:0] recip;
  logic signed [15:0] adj;
  logic               adjv;
  logic               slip;
  logic signed [7:0]  dox;
  logic signed [7:0]  doy;
  logic               ov;
  logic               fv;

  modport master (
    output dix, diy, iv, step, recip, adj, adjv, slip,
    input  dox, doy, ov, fv
  );

  modport slave (
    input  dix, diy, iv, step, recip, adj, adjv, slip,
    output dox, doy, ov, fv
  );
endinterface

// File: rtl/resamp2x.sv
// resamp2x: fractional resampler producing two samples per symbol.
// A 16-bit phase accumulator advances by step (+ any pending adjustment) on
// every input; a carry out places an output between the two latest inputs,
// found by linear interpolation. Every second output is flagged with fv.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset; flushes the pipeline
//   bus  : resamp2x_if.slave (inputs dix/diy/iv/step/recip/adj/adjv/slip,
//          outputs dox/doy/ov/fv)
// Pipeline for an iv in cycle 0: accumulator/wrap in cycle 0, fraction
// multiply in cycle 1, interpolation multiply in cycle 2, ov visible in cycle 3.
// Build option: define RESAMP2X_ROUND_EN to round the interpolation half-up
// instead of truncating toward minus infinity.
module resamp2x (
  input logic        clk,
  input logic        rst,
  resamp2x_if.slave  bus
);

  logic        [15:0] acc_q;
  logic signed [7:0]  x0_q, x1_q, y0_q, y1_q;
  logic signed [15:0] pend_q;
  logic               h_q, h_d;

  // Stage 1: residual phase and wrap flag
  logic        [15:0] r_q;
  logic               v1_q, f1_q;
  // Stage 2: fraction
  logic        [7:0]  m_q;
  logic               v2_q, f2_q;
  // Output registers
  logic signed [7:0]  dox_q, doy_q;
  logic               ov_q, fv_q;

  logic signed [17:0] inc_raw;
  logic        [15:0] inc;
  logic        [16:0] sum;
  logic               wrap;
  logic        [15:0] frac16;
  logic        [7:0]  m_d;

  // y = a1 + ((a0 - a1) * m) >> 8, arithmetic shift. The result always lies
  // between a0 and a1, so keeping the low 8 bits of the sum is exact.
  function automatic logic signed [7:0] interp(input logic signed [7:0] a0,
                                               input logic signed [7:0] a1,
                                               input logic        [7:0] m);
    logic signed [8:0]  d;
    logic signed [16:0] p;
    logic signed [7:0]  q;
    d = {a0[7], a0} - {a1[7], a1};
    p = d * $signed({1'b0, m});
`ifdef RESAMP2X_ROUND_EN
    p = p + 17'sd128;
`else
    p = p + 17'sd0;
`endif
    q = 8'(p >>> 8);
    return a1 + q;
  endfunction

  always_comb begin
    inc_raw = $signed({2'b00, bus.step}) + $signed({{2{pend_q[15]}}, pend_q});
    // Clamp the adjusted increment to [0, 0xFFFF]
    if (inc_raw[17]) begin
      inc = 16'h0000;
    end else if (inc_raw[16]) begin
      inc = 16'hFFFF;
    end else begin
      inc = inc_raw[15:0];
    end
    sum  = {1'b0, acc_q} + {1'b0, inc};
    wrap = bus.iv & sum[16];

    // The half-symbol flag toggles per output; a slip inverts it afterwards
    h_d = h_q ^ wrap ^ bus.slip;

    frac16 = 16'(({16'd0, r_q} * {16'd0, bus.recip}) >> 16);
    m_d    = (frac16[15:8] != 8'd0) ? 8'hFF : frac16[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      x0_q   <= '0;
      x1_q   <= '0;
      y0_q   <= '0;
      y1_q   <= '0;
      pend_q <= '0;
      h_q    <= 1'b0;
      r_q    <= '0;
      v1_q   <= 1'b0;
      f1_q   <= 1'b0;
      m_q    <= '0;
      v2_q   <= 1'b0;
      f2_q   <= 1'b0;
      dox_q  <= '0;
      doy_q  <= '0;
      ov_q   <= 1'b0;
      fv_q   <= 1'b0;
    end else begin
      if (bus.iv) begin
        x0_q  <= x1_q;
        x1_q  <= bus.dix;
        y0_q  <= y1_q;
        y1_q  <= bus.diy;
        // Low 16 bits are sum - 0x10000 on a wrap and sum otherwise
        acc_q <= sum[15:0];
        r_q   <= sum[15:0];
        // A coincident strobe is kept for the following input
        pend_q <= bus.adjv ? bus.adj : 16'sd0;
      end else if (bus.adjv) begin
        pend_q <= bus.adj;
      end
      h_q  <= h_d;
      v1_q <= wrap;
      f1_q <= h_q;

      m_q  <= m_d;
      v2_q <= v1_q;
      f2_q <= f1_q;

      // Inputs are spaced at least 4 clocks, so x0/x1 are still this output's pair
      ov_q <= v2_q;
      if (v2_q) begin
        dox_q <= interp(x0_q, x1_q, m_q);
        doy_q <= interp(y0_q, y1_q, m_q);
        fv_q  <= f2_q;
      end
    end
  end

  assign bus.dox = dox_q;
  assign bus.doy = doy_q;
  assign bus.ov  = ov_q;
  assign bus.fv  = fv_q;

endmodule

// File: tb/tb_resamp2x.sv
// Bench for resamp2x: directed vectors, a per-cycle comparison against an
// arithmetic model of the resampler, and literal expectations per scenario.
module tb_resamp2x;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  resamp2x_if bus ();

  resamp2x dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    int x;
    int y;
    bit fv;
  } exp_t;

  exp_t expq[$];

  // Model state
  int m_acc, m_pend, m_x0, m_x1, m_y0, m_y1;
  bit m_h;
  int step_v, recip_v;

  // Values the outputs must currently hold
  int hx, hy;
  bit hfv;
  int clr_at = -1;
  bit armed = 1'b0;

  int nvec = 0;
  int nbad = 0;
  int obs_x[$];
  int obs_y[$];
  int obs_fv[$];

  task automatic chk(input string name, input logic signed [31:0] act, input int exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int floor_div256(input int p);
    if (p >= 0) return p / 256;
    return -((-p + 255) / 256);
  endfunction

  function automatic int lerp(input int a0, input int a1, input int mm);
    return a1 + floor_div256((a0 - a1) * mm);
  endfunction

  function automatic int ox(input int i);
    return (i < obs_x.size()) ? obs_x[i] : -999;
  endfunction

  function automatic int oy(input int i);
    return (i < obs_y.size()) ? obs_y[i] : -999;
  endfunction

  function automatic int ofv(input int i);
    return (i < obs_fv.size()) ? obs_fv[i] : -999;
  endfunction

  task automatic model_cycle(input bit r, input bit v, input int x, input int y,
                             input bit av, input int a, input bit sl);
    int inc;
    int s;
    longint prod;
    int mm;
    bit wrapped;
    exp_t e;
    wrapped = 1'b0;
    if (r) begin
      while (expq.size() > 0 && expq[$].due > cyc) void'(expq.pop_back());
      clr_at = cyc + 1;
      m_acc = 0; m_pend = 0; m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0; m_h = 1'b0;
      return;
    end
    if (v) begin
      inc = step_v + m_pend;
      if (inc < 0) inc = 0;
      if (inc > 65535) inc = 65535;
      s = m_acc + inc;
      m_x0 = m_x1; m_x1 = x;
      m_y0 = m_y1; m_y1 = y;
      if (s >= 65536) begin
        m_acc = s - 65536;
        prod = longint'(m_acc) * longint'(recip_v);
        mm = int'(prod >> 16);
        if (mm > 255) mm = 255;
        e.due = cyc + 3;
        e.x = lerp(m_x0, m_x1, mm);
        e.y = lerp(m_y0, m_y1, mm);
        e.fv = m_h;
        expq.push_back(e);
        wrapped = 1'b1;
      end else begin
        m_acc = s;
      end
      m_pend = av ? a : 0;
    end else if (av) begin
      m_pend = a;
    end
    if (wrapped) m_h = ~m_h;
    if (sl) m_h = ~m_h;
  endtask

  // Entered just after a rising edge; drives one cycle and returns after the next edge
  task automatic tick(input bit r, input bit v, input int x, input int y,
                      input bit av, input int a, input bit sl);
    rst = r;
    bus.iv = v;
    bus.dix = x[7:0];
    bus.diy = y[7:0];
    bus.adjv = av;
    bus.adj = a[15:0];
    bus.slip = sl;
    bus.step = step_v[15:0];
    bus.recip = recip_v[15:0];
    model_cycle(r, v, x, y, av, a, sl);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic put(input int x, input int y);
    tick(1'b0, 1'b1, x, y, 1'b0, 0, 1'b0);
    repeat (3) idle();
  endtask

  task automatic clear_obs();
    obs_x.delete();
    obs_y.delete();
    obs_fv.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit eov;
    if (armed) begin
      eov = 1'b0;
      if (cyc == clr_at) begin
        hx = 0; hy = 0; hfv = 1'b0;
      end
      if (expq.size() > 0 && expq[0].due == cyc) begin
        e = expq.pop_front();
        hx = e.x; hy = e.y; hfv = e.fv;
        eov = 1'b1;
      end
      chk("ov", {31'd0, bus.ov}, int'(eov));
      chk("dox", 32'($signed(bus.dox)), hx);
      chk("doy", 32'($signed(bus.doy)), hy);
      chk("fv", {31'd0, bus.fv}, int'(hfv));
      if (bus.ov === 1'b1) begin
        obs_x.push_back(int'($signed(bus.dox)));
        obs_y.push_back(int'($signed(bus.doy)));
        obs_fv.push_back(int'(bus.fv));
      end
    end
  end

  initial begin
    hx = 0; hy = 0; hfv = 1'b0;
    m_acc = 0; m_pend = 0; m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0; m_h = 1'b0;
    step_v = 0;
    recip_v = 'h0200;
    rst = 1'b1;
    bus.iv = 1'b0; bus.dix = '0; bus.diy = '0; bus.adjv = 1'b0; bus.adj = '0;
    bus.slip = 1'b0; bus.step = '0; bus.recip = 16'h0200;
    repeat (2) @(posedge clk);
    #1;
    armed = 1'b1;

    // Idle with step = 0: no outputs at all
    clear_obs();
    for (int i = 0; i < 5; i++) put(i * 7 + 3, -i);
    chk("idle_count", obs_x.size(), 0);

    // Nominal 2x decimation of a ramp
    step_v = 'h8000;
    tick(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    idle();
    clear_obs();
    for (int i = 1; i <= 8; i++) put(i, -i);
    chk("nom_count", obs_x.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("nom_x", ox(i), 2 * (i + 1));
      chk("nom_y", oy(i), -2 * (i + 1));
      chk("nom_fv", ofv(i), i % 2);
    end

    // Half-step adjustment between x0 = 20 and x1 = 60
    clear_obs();
    put(20, -20);
    tick(1'b0, 1'b0, 0, 0, 1'b1, 'h4000, 1'b0);
    put(60, -60);
    put(70, -70);
    put(80, -80);
    chk("adj_count", obs_x.size(), 2);
    chk("adj_x0", ox(0), 40);
    chk("adj_y0", oy(0), -40);
    chk("adj_x1", ox(1), 75);
    chk("adj_fv1", ofv(1), 1);

    // Negative adjustment clamps the increment to 0
    clear_obs();
    step_v = 'h7F00;
    tick(1'b0, 1'b0, 0, 0, 1'b1, -32768, 1'b0);
    put(90, 0);
    step_v = 'h8000;
    put(-100, 0);
    put(100, 0);
    chk("sat_count", obs_x.size(), 1);
    chk("sat_x", ox(0), 0);

    // Slip shifts the fv pattern
    clear_obs();
    tick(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b1);
    put(10, 0);
    put(20, 0);
    put(30, 0);
    put(40, 0);
    chk("slip_count", obs_x.size(), 2);
    chk("slip_x0", ox(0), 15);
    chk("slip_fv0", ofv(0), 0);
    chk("slip_fv1", ofv(1), 1);

    // adjv coincident with iv applies to the following input only
    clear_obs();
    tick(1'b0, 1'b1, 0, 0, 1'b1, 'h6000, 1'b0);
    repeat (3) idle();
    put(100, 0);
    chk("coin_count", obs_x.size(), 1);
    chk("coin_x", ox(0), 0);

    // Reset one clock after a wrapping input; iv during reset is ignored
    clear_obs();
    tick(1'b0, 1'b1, 5, 0, 1'b0, 0, 1'b0);
    tick(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    tick(1'b1, 1'b1, 99, 0, 1'b0, 0, 1'b0);
    repeat (3) idle();
    put(7, 0);
    put(9, 0);
    chk("rst_count", obs_x.size(), 1);
    chk("rst_x", ox(0), 9);
    chk("rst_fv", ofv(0), 0);

    chk("drain", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
